// File: rtl/rv32i_dmem_arbiter.sv
// Two-master (core / DMA) arbiter for the single data-memory port.
// Round-robin on conflict, one outstanding transaction, timeout abort with error.
module rv32i_dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wmask,
    output logic              core_ack,
    output logic              core_err,
    output logic [31:0]       core_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_wmask,
    output logic              dma_ack,
    output logic              dma_err,
    output logic [31:0]       dma_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ABORT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          win_dma;
    logic          last_dma;
    logic          grant_dma;
    logic          timeout_hit;

    // DMA wins when alone, or on conflict when the core had the last grant
    assign grant_dma   = dma_req & (~core_req | ~last_dma);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:        if (core_req || dma_req) state_nx = BUSY;
            BUSY: begin
                if (mem_ack)          state_nx = RESP;
                else if (timeout_hit) state_nx = ABORT;
            end
            RESP, ABORT: state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        core_ack = 1'b0;
        core_err = 1'b0;
        dma_ack  = 1'b0;
        dma_err  = 1'b0;
        if (state == RESP || state == ABORT) begin
            if (win_dma) dma_ack  = 1'b1;
            else         core_ack = 1'b1;
        end
        if (state == ABORT) begin
            if (win_dma) dma_err  = 1'b1;
            else         core_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            win_dma    <= 1'b0;
            last_dma   <= 1'b1;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            core_rdata <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (core_req || dma_req) begin
                    win_dma   <= grant_dma;
                    last_dma  <= grant_dma;
                    cnt       <= '0;
                    mem_req   <= 1'b1;
                    mem_wr    <= grant_dma ? dma_wr    : core_wr;
                    mem_addr  <= grant_dma ? dma_addr  : core_addr;
                    mem_wdata <= grant_dma ? dma_wdata : core_wdata;
                    // loads never carry a byte mask to memory
                    if (grant_dma) mem_wmask <= dma_wr  ? dma_wmask  : 4'b0000;
                    else           mem_wmask <= core_wr ? core_wmask : 4'b0000;
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (win_dma) dma_rdata  <= mem_rdata;
                        else         core_rdata <= mem_rdata;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        if (win_dma) dma_rdata  <= '0;
                        else         core_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
